// File: rtl/uart_apb_pkg.sv
// Shared register offsets, STATUS bit positions and serial state encodings
// for the APB UART peripheral.
package uart_apb_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_BAUD   = 2'd2;

    localparam int unsigned SB_TX_FULL   = 0;
    localparam int unsigned SB_TX_EMPTY  = 1;
    localparam int unsigned SB_RX_FULL   = 2;
    localparam int unsigned SB_RX_EMPTY  = 3;
    localparam int unsigned SB_TX_BUSY   = 4;
    localparam int unsigned SB_OVERRUN   = 5;
    localparam int unsigned SB_FRAME_ERR = 6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with full/empty flags; pushes when full and pops when
// empty are ignored.
module uart_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_apb.sv
// APB3 slave wrapping an 8N1 UART: TX/RX FIFOs, 16x-oversampled baud
// generator, DATA/STATUS/BAUD register map.
module uart_apb
    import uart_apb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd1
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic [31:0] PADDR,
    input  logic        PSELx,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    input  logic        rx,
    output logic        tx
);

    logic [1:0]  addr;
    logic        access, commit, tx_push, rx_pop, st_wr, baud_wr;
    logic        tx_full, tx_empty, rx_full, rx_empty, tx_pop, rx_push;
    logic [7:0]  tx_rdata, rx_rdata;
    logic [31:0] status;
    logic [15:0] div_q, div_d, cnt_q, cnt_d, eff_div;
    logic        tick;

    uart_state_e tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [3:0]  tx_tcnt_q, tx_tcnt_d, rx_tcnt_q, rx_tcnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    logic        ovr_q, ovr_d, ferr_q, ferr_d;
    logic        unused_bits;

    assign unused_bits = ^{PADDR[31:4], PADDR[1:0], PWDATA[31:16]};

    assign addr    = PADDR[3:2];
    assign access  = PSELx & PENABLE;
    assign PREADY  = ~(access & PWRITE & (addr == ADDR_DATA) & tx_full);
    assign commit  = access & PREADY;
    assign tx_push = commit & PWRITE & (addr == ADDR_DATA);
    assign rx_pop  = commit & ~PWRITE & (addr == ADDR_DATA);
    assign st_wr   = commit & PWRITE & (addr == ADDR_STATUS);
    assign baud_wr = commit & PWRITE & (addr == ADDR_BAUD);

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i(PCLK), .rst_ni(PRESETn), .push_i(tx_push), .pop_i(tx_pop),
        .wdata_i(PWDATA[7:0]), .rdata_o(tx_rdata), .full_o(tx_full), .empty_o(tx_empty)
    );

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i(PCLK), .rst_ni(PRESETn), .push_i(rx_push), .pop_i(rx_pop),
        .wdata_i(rx_shift_q), .rdata_o(rx_rdata), .full_o(rx_full), .empty_o(rx_empty)
    );

    always_comb begin
        status               = '0;
        status[SB_TX_FULL]   = tx_full;
        status[SB_TX_EMPTY]  = tx_empty;
        status[SB_RX_FULL]   = rx_full;
        status[SB_RX_EMPTY]  = rx_empty;
        status[SB_TX_BUSY]   = (tx_state_q != S_IDLE);
        status[SB_OVERRUN]   = ovr_q;
        status[SB_FRAME_ERR] = ferr_q;
    end

    always_comb begin
        PRDATA = '0;
        if (PRESETn && access && !PWRITE) begin
            case (addr)
                ADDR_DATA:   PRDATA = rx_empty ? '0 : {24'b0, rx_rdata};
                ADDR_STATUS: PRDATA = status;
                ADDR_BAUD:   PRDATA = {16'b0, div_q};
                default:     PRDATA = '0;
            endcase
        end
    end

    // Divisor 0 is treated as 1; a BAUD write restarts the tick phase.
    assign eff_div = (div_q == '0) ? 16'd1 : div_q;
    assign tick    = (cnt_q >= eff_div - 16'd1);
    assign div_d   = baud_wr ? PWDATA[15:0] : div_q;
    assign cnt_d   = (baud_wr || tick) ? '0 : cnt_q + 16'd1;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_tcnt_d  = tx_tcnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        if (tx_state_q == S_IDLE) begin
            if (!tx_empty) begin
                tx_pop     = 1'b1;
                tx_shift_d = tx_rdata;
                tx_tcnt_d  = '0;
                tx_state_d = S_START;
            end
        end else if (tick) begin
            tx_tcnt_d = tx_tcnt_q + 4'd1;
            if (tx_tcnt_q == 4'd15) begin
                case (tx_state_q)
                    S_START: begin
                        tx_state_d = S_DATA;
                        tx_bit_d   = '0;
                    end
                    S_DATA: begin
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_bit_d   = tx_bit_q + 3'd1;
                        if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
                    end
                    default: tx_state_d = S_IDLE;
                endcase
            end
        end
    end

    assign tx = (tx_state_q == S_START) ? 1'b0 :
                (tx_state_q == S_DATA)  ? tx_shift_q[0] : 1'b1;

    // Sticky flags: W1C applied first so a same-cycle hardware set wins.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_tcnt_d  = rx_tcnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_push    = 1'b0;
        ovr_d      = ovr_q & ~(st_wr & PWDATA[SB_OVERRUN]);
        ferr_d     = ferr_q & ~(st_wr & PWDATA[SB_FRAME_ERR]);
        case (rx_state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_d = S_START;
                    rx_tcnt_d  = '0;
                end
            end
            S_START: begin
                if (tick) begin
                    rx_tcnt_d = rx_tcnt_q + 4'd1;
                    if (rx_tcnt_q == 4'd7) begin
                        rx_tcnt_d  = '0;
                        rx_bit_d   = '0;
                        rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    rx_tcnt_d = rx_tcnt_q + 4'd1;
                    if (rx_tcnt_q == 4'd15) begin
                        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                        rx_bit_d   = rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
                    end
                end
            end
            default: begin
                if (tick) begin
                    rx_tcnt_d = rx_tcnt_q + 4'd1;
                    if (rx_tcnt_q == 4'd15) begin
                        rx_state_d = S_IDLE;
                        if (!rx_s2_q)     ferr_d  = 1'b1;
                        else if (rx_full) ovr_d   = 1'b1;
                        else              rx_push = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            div_q      <= DEFAULT_DIV;
            cnt_q      <= '0;
            tx_state_q <= S_IDLE;
            tx_tcnt_q  <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            rx_state_q <= S_IDLE;
            rx_tcnt_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            tx_state_q <= tx_state_d;
            tx_tcnt_q  <= tx_tcnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            rx_state_q <= rx_state_d;
            rx_tcnt_q  <= rx_tcnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_s1_q    <= rx;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            ovr_q      <= ovr_d;
            ferr_q     <= ferr_d;
        end
    end

endmodule

// File: tb/tb_uart_apb.sv
// Directed bench for uart_apb: APB register accesses, TX waveform/frame
// decoding against a byte queue, RX frames driven from the bench.
module tb_uart_apb;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PSELx, PENABLE, PWRITE, PREADY;
    logic        rx, tx, rx_drv, loop_en, mon_en;

    int unsigned compared = 0;
    int unsigned mismatched = 0;
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];
    logic [31:0] rd_q[$];

    localparam logic [31:0] A_DATA = 32'h0, A_STATUS = 32'h4, A_BAUD = 32'h8, A_RSVD = 32'hC;
    localparam int unsigned WAIT_LIMIT = 400;

    assign rx = loop_en ? tx : rx_drv;

    uart_apb #(.FIFO_DEPTH(4), .DEFAULT_DIV(16'd1)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PSELx(PSELx),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .rx(rx), .tx(tx)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge PCLK);
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1 d = PRDATA;
        @(negedge PCLK);
        PSELx = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic read_check(input logic [31:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] d;
        rd_q.push_back(exp);
        apb_read(a, d);
        check(tag, d, rd_q.pop_front());
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output int unsigned waits);
        @(negedge PCLK);
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(negedge PCLK);
        PENABLE = 1'b1;
        waits = 0;
        #1;
        while (PREADY !== 1'b1 && waits < WAIT_LIMIT) begin
            @(negedge PCLK);
            #1 waits++;
        end
        if (waits >= WAIT_LIMIT) check("pready_timeout", {31'b0, PREADY}, 32'd1);
        @(negedge PCLK);
        PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        @(negedge PCLK);
        rx_drv = 1'b0;
        repeat (16) @(negedge PCLK);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (16) @(negedge PCLK);
        end
        rx_drv = stop_bit;
        repeat (16) @(negedge PCLK);
        rx_drv = 1'b1;
    endtask

    // TX frame decoder: samples mid-bit, assuming 16 PCLK per bit.
    initial begin
        logic [7:0] mb;
        logic       ms, mp;
        forever begin
            @(negedge PCLK);
            if (mon_en && tx === 1'b0) begin
                repeat (8) @(negedge PCLK);
                ms = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (16) @(negedge PCLK);
                    mb[i] = tx;
                end
                repeat (16) @(negedge PCLK);
                mp = tx;
                check("tx_frame_expected", {31'b0, tx_q.size() != 0}, 32'd1);
                if (tx_q.size() != 0) check("tx_byte", {24'b0, mb}, {24'b0, tx_q.pop_front()});
                check("tx_start_mid", {31'b0, ms}, 32'd0);
                check("tx_stop_mid", {31'b0, mp}, 32'd1);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, compared %0d", compared);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned w;
        int unsigned waits[6];
        logic [7:0]  bytes6[6];
        logic [7:0]  rxb[5];
        logic [7:0]  pat;
        logic        expb;
        int unsigned n, errs;

        bytes6 = '{8'hAA, 8'h33, 8'h55, 8'hC3, 8'h0F, 8'h81};
        rxb    = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
        mon_en = 1'b1; loop_en = 1'b0; rx_drv = 1'b1;
        PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;

        // 1: reset values, with a read access held during reset
        PRESETn = 1'b0;
        PSELx = 1'b1; PENABLE = 1'b1; PADDR = A_STATUS;
        repeat (2) @(negedge PCLK);
        check("reset_prdata", PRDATA, 32'd0);
        check("reset_pready", {31'b0, PREADY}, 32'd1);
        check("reset_tx", {31'b0, tx}, 32'd1);
        PSELx = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        read_check(A_STATUS, 32'h0000000A, "status_reset");
        read_check(A_BAUD, 32'd1, "baud_reset");
        read_check(A_DATA, 32'd0, "data_empty_read");
        read_check(A_RSVD, 32'd0, "reserved_read");
        apb_write(A_BAUD, 32'h0003, w);
        read_check(A_BAUD, 32'd3, "baud_rw");
        apb_write(A_BAUD, 32'h0001, w);

        // 2: single frame 0xAA, exact waveform at 16 cycles per bit
        pat = 8'hAA;
        tx_q.push_back(pat);
        apb_write(A_DATA, {24'b0, pat}, w);
        fork
            begin
                n = 0;
                while (tx !== 1'b0 && n < 40) begin
                    @(negedge PCLK);
                    n++;
                end
                check("tx_start_seen", {31'b0, tx}, 32'd0);
                errs = 0;
                for (int i = 0; i < 160; i++) begin
                    if (i < 16)       expb = 1'b0;
                    else if (i < 144) expb = pat[(i - 16) / 16];
                    else              expb = 1'b1;
                    if (tx !== expb) errs++;
                    @(negedge PCLK);
                end
                check("tx_waveform_AA", errs, 32'd0);
            end
            begin
                repeat (70) @(negedge PCLK);
                read_check(A_STATUS, 32'h0000001A, "status_tx_busy");
            end
        join
        repeat (4) @(negedge PCLK);
        read_check(A_STATUS, 32'h0000000A, "status_after_frame");

        // 3: six writes; the sixth stalls until the first frame ends
        for (int i = 0; i < 6; i++) begin
            tx_q.push_back(bytes6[i]);
            apb_write(A_DATA, {24'b0, bytes6[i]}, waits[i]);
        end
        for (int i = 0; i < 5; i++) check("write_no_stall", waits[i], 32'd0);
        check("sixth_write_stalled", {31'b0, waits[5] > 100 && waits[5] < 200}, 32'd1);
        read_check(A_STATUS, 32'h00000019, "status_tx_full");
        repeat (5 * 170) @(negedge PCLK);
        check("tx_queue_drained", tx_q.size(), 32'd0);
        read_check(A_STATUS, 32'h0000000A, "status_tx_done");

        // 4: loopback with BAUD=0 (acts as 1)
        loop_en = 1'b1;
        apb_write(A_BAUD, 32'h0000, w);
        read_check(A_BAUD, 32'd0, "baud_zero");
        tx_q.push_back(8'h33);
        apb_write(A_DATA, 32'h33, w);
        repeat (170) @(negedge PCLK);
        read_check(A_STATUS, 32'h00000002, "status_rx_ready");
        read_check(A_DATA, 32'h33, "loopback_byte");
        read_check(A_DATA, 32'd0, "loopback_empty");
        read_check(A_STATUS, 32'h0000000A, "status_rx_drained");
        check("loop_tx_queue", tx_q.size(), 32'd0);
        loop_en = 1'b0;
        apb_write(A_BAUD, 32'h0001, w);

        // 5: framing error, then W1C
        send_rx(8'h5A, 1'b0);
        repeat (4) @(negedge PCLK);
        read_check(A_STATUS, 32'h0000004A, "frame_error_set");
        apb_write(A_STATUS, 32'h40, w);
        read_check(A_STATUS, 32'h0000000A, "frame_error_clear");

        // 6: overrun on the fifth byte; first four read back in order
        for (int k = 0; k < 5; k++) begin
            if (k < 4) rx_q.push_back(rxb[k]);
            send_rx(rxb[k], 1'b1);
        end
        repeat (4) @(negedge PCLK);
        read_check(A_STATUS, 32'h00000026, "overrun_set");
        for (int k = 0; k < 4; k++) read_check(A_DATA, {24'b0, rx_q.pop_front()}, "rx_order");
        read_check(A_STATUS, 32'h0000002A, "overrun_sticky");

        // mid-frame reset while transmitting 0x0F
        mon_en = 1'b0;
        apb_write(A_DATA, 32'h0F, w);
        repeat (100) @(negedge PCLK);
        check("tx_mid_frame_low", {31'b0, tx}, 32'd0);
        apb_write(A_BAUD, 32'h0005, w);
        #2 PRESETn = 1'b0;
        #1;
        check("reset_tx_immediate", {31'b0, tx}, 32'd1);
        PSELx = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = A_STATUS;
        #1;
        check("reset_prdata_mid", PRDATA, 32'd0);
        check("reset_pready_mid", {31'b0, PREADY}, 32'd1);
        PSELx = 1'b0; PENABLE = 1'b0;
        repeat (3) @(negedge PCLK);
        PRESETn = 1'b1;
        mon_en = 1'b1;
        read_check(A_STATUS, 32'h0000000A, "status_after_reset");
        read_check(A_BAUD, 32'd1, "baud_after_reset");
        repeat (20) @(negedge PCLK);
        check("tx_idle_after_reset", {31'b0, tx}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_apb.md
Name: uart_apb

Overview:
APB3-style slave peripheral wrapping an 8N1 UART transmitter and receiver, each buffered by a small FIFO. The CPU bus writes bytes into the TX FIFO and reads received bytes from the RX FIFO. It also reads status flags and programs a baud divisor through a three-register map. The block sits on the peripheral APB bus; `tx` and `rx` go to the pads.

Parameters:
- FIFO_DEPTH, 4, entries per TX/RX FIFO (power of 2, ≥2).
- DEFAULT_DIV, 1, reset value of the BAUD register (PCLK cycles per 16x-oversample tick).

Ports:
- PCLK  in  1  system clock; all logic rises on posedge.
- PRESETn  in  1  asynchronous, active-low reset.
- PADDR  in  32  byte address; only PADDR[3:2] are decoded.
- PSELx  in  1  slave select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  transfer-complete / wait-state control.
- rx  in  1  serial input, asynchronous to PCLK.
- tx  out  1  serial output; idle high.

Behaviour:
Clock and reset:
- Single clock PCLK; reset is asynchronous, active-low (PRESETn).
- Reset, including mid-frame, forces:
  - tx=1, PRDATA=0, PREADY=1.
  - Both FIFOs empty, TX/RX state machines IDLE.
  - Sticky flags cleared; BAUD=DEFAULT_DIV.

APB access:
- Access cycle = PSELx & PENABLE. The register action commits on the PCLK edge ending an access cycle with PREADY=1.
- A missing setup phase is tolerated.
- PREADY is combinational. It is 0 only during a write access to DATA while the TX FIFO is full; otherwise it is 1. The stall releases the cycle after a FIFO entry frees.
- PRDATA is combinational from PADDR[3:2] during a read access; 0 otherwise.

Register map (PADDR[3:2]):
- 0 DATA:
  - Write pushes PWDATA[7:0] into the TX FIFO.
  - Read returns {24'b0, RX FIFO head} and pops it. If the RX FIFO is empty, the read returns 0 with no pop and no stall.
- 1 STATUS, read-only except W1C bits:
  - [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] tx_busy.
  - [5] rx_overrun (sticky, W1C), [6] frame_error (sticky, W1C).
  - Reset value 0x0000000A.
- 2 BAUD: [15:0] divisor, read/write. A value of 0 behaves as 1.
- 3: reads 0, writes ignored.

Baud generator:
- Counter emits a 1-cycle tick every BAUD PCLK cycles.
- Writing BAUD restarts the counter.
- One bit = 16 ticks.

Transmitter:
- IDLE pops the TX FIFO when it is non-empty and loads the shifter. TX capacity is therefore FIFO_DEPTH+1 bytes.
- Frame: START (tx=0, 16 ticks), DATA (8 bits, LSB first, 16 ticks each), STOP (tx=1, 16 ticks), then back to IDLE.
- tx_busy=1 from load to the end of STOP.

Receiver:
- rx passes through a 2-flop synchronizer.
- IDLE detects a falling edge, then moves to START.
- START waits 8 ticks and re-samples: if high it is a false start and returns to IDLE; otherwise it moves to DATA.
- DATA samples every 16 ticks, 8 bits, LSB first.
- STOP samples at mid-bit:
  - 1: push the byte to the RX FIFO; if the FIFO is full, drop the byte and set rx_overrun.
  - 0: discard the byte and set frame_error.

FIFOs:
- Simultaneous push and pop on a non-empty, non-full FIFO leaves the count unchanged.
- A push when full is never performed.

Decomposition:
- Package uart_apb_pkg:
  - Register offsets (ADDR_DATA=0, ADDR_STATUS=1, ADDR_BAUD=2).
  - STATUS bit indices.
  - TX/RX state enums (IDLE, START, DATA, STOP).
- Sub-module uart_fifo (WIDTH=8, DEPTH): synchronous FIFO with full/empty flags. It is instantiated twice (TX, RX).
- TX, RX and baud logic stay inline.

Test Plan:
1. Reset, then read STATUS → 0x0000000A; read BAUD → 1; tx=1.
2. Write DATA=0xAA (BAUD=1) → tx: 16 cycles 0, then bits 0,1,0,1,0,1,0,1 at 16 cycles each, then 16 cycles 1; tx_busy high throughout.
3. Six back-to-back DATA writes (0xAA, 0x33, …) → the first five complete with PREADY=1; the sixth holds PREADY=0 until the first frame ends, then completes.
4. Loop tx→rx, write 0x33, wait 170 cycles → STATUS[3]=0; read DATA → 0x33; a second read → 0 with rx_empty=1.
5. Drive an rx frame 0x5A with stop bit=0 → frame_error=1, RX FIFO empty; write STATUS=0x40 → frame_error clears.
6. Send FIFO_DEPTH+1 rx frames without reading → rx_overrun=1 and the first 4 bytes read back in order. Assert PRESETn low mid-frame → tx=1 immediately and STATUS=0x0A.
